// File: rtl/fmap_pkg.sv
// fmap_pkg: shared sizes, channel index type and ping-pong region address helper
package fmap_pkg;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 192;
  localparam int ADDR_W = 12;
  localparam int COL_W = 5;
  localparam int REGION_WORDS = 24;
  localparam logic [ADDR_W-1:0] BASE_ADDR = 12'h000;
  localparam int BANK_WORDS = NUM_CH * REGION_WORDS;
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef logic [CH_W-1:0] ch_t;
  function automatic logic [ADDR_W-1:0] region_addr(input logic bank, input ch_t ch, input logic [COL_W-1:0] col);
    return ADDR_W'(int'(BASE_ADDR) + (bank ? BANK_WORDS : 0) + int'(ch) * REGION_WORDS + int'(col));
  endfunction
endpackage

// File: rtl/fmap_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first eligible at or above rr_ptr
module rr_arbiter import fmap_pkg::*; #(
  parameter int NUM_CH = fmap_pkg::NUM_CH
) (
  input  logic [NUM_CH-1:0] elig,
  input  ch_t               rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output ch_t               idx
);
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = 0;
    // scan from farthest to nearest so the closest eligible channel wins
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_CH;
      if (elig[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = ch_t'(j);
      end
    end
  end
endmodule

// File: rtl/fmap_wr_arbiter.sv
// fmap_wr_arbiter: round-robin share of one BRAM write port across capture channels
// with ping-pong bank selection and per-frame completion tracking.
module fmap_wr_arbiter import fmap_pkg::*; (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_clr,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_last,
  input  logic [NUM_CH*COL_W-1:0]  req_col,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]        bram_addr_a,
  output logic [DATA_W-1:0]        bram_wrdata_a,
  output logic                     bram_we_a,
  output logic                     frame_done,
  output logic                     done_bank,
  output logic                     wr_bank,
  output logic                     err_col
);
  logic [NUM_CH-1:0] done_mask, elig, grant;
  ch_t rr_ptr, g;
  logic accept, acc_last, in_range, close;
  logic [COL_W-1:0] col;
  assign elig = req_valid & ~done_mask & {NUM_CH{~soft_clr}};
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (g)
  );
  assign req_ready = grant;
  assign accept = |grant;
  assign col = req_col[g*COL_W +: COL_W];
  assign acc_last = accept & req_last[g];
  assign in_range = int'(col) < REGION_WORDS;
  // the frame closes on the edge that completes the last outstanding channel
  assign close = acc_last & ((done_mask | grant) == {NUM_CH{1'b1}});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_addr_a <= BASE_ADDR;
      bram_wrdata_a <= '0;
      bram_we_a <= 1'b0;
      frame_done <= 1'b0;
      done_bank <= 1'b0;
      wr_bank <= 1'b0;
      err_col <= 1'b0;
      done_mask <= '0;
      rr_ptr <= '0;
    end else if (soft_clr) begin
      wr_bank <= 1'b0;
      done_mask <= '0;
      rr_ptr <= '0;
      bram_we_a <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bram_we_a <= accept & in_range;
      frame_done <= close;
      if (accept & in_range) begin
        bram_addr_a <= region_addr(wr_bank, g, col);
        bram_wrdata_a <= req_data[g*DATA_W +: DATA_W];
      end
      if (accept) rr_ptr <= (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
      if (accept & ~in_range) err_col <= 1'b1;
      if (close) begin
        done_bank <= wr_bank;
        wr_bank <= ~wr_bank;
        done_mask <= '0;
      end else if (acc_last) begin
        done_mask <= done_mask | grant;
      end
    end
  end
endmodule

// File: doc/fmap_wr_arbiter.md
Name: fmap_wr_arbiter

Overview:
- Shares one BRAM write port (port A) between NUM_CH feature-map capture channels.
- Each channel streams grayscale column words with a local column index.
- The block arbitrates round-robin and maps each write into a per-channel region of a ping-pong (two-bank) frame buffer.
- It tracks per-channel frame completion and pulses frame_done with the completed bank, so the readout/display side can consume one bank while the next frame fills the other.

Parameters:
NUM_CH, 4, number of requesting capture channels
DATA_W, 192, BRAM word width (24 pixels x 8 bit)
ADDR_W, 12, BRAM address width
COL_W, 5, width of per-channel local column index
REGION_WORDS, 24, words per channel region (columns per fmap); must be <= 2**COL_W
BASE_ADDR, 12'h000, first BRAM address of bank 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
soft_clr  in  1  synchronous clear of bank, done mask and rr pointer
req_valid  in  NUM_CH  per-channel write request
req_ready  out  NUM_CH  per-channel accept (combinational)
req_last  in  NUM_CH  beat is the channel's final column of the frame
req_col  in  NUM_CH*COL_W  local column index, channel i at [i*COL_W +: COL_W]
req_data  in  NUM_CH*DATA_W  column word, channel i at [i*DATA_W +: DATA_W]
bram_addr_a  out  ADDR_W  BRAM write address (registered)
bram_wrdata_a  out  DATA_W  BRAM write data (registered)
bram_we_a  out  1  BRAM write enable (registered)
frame_done  out  1  one-cycle pulse: all channels finished a frame
done_bank  out  1  bank just completed; valid while frame_done=1, held afterwards
wr_bank  out  1  bank currently being filled
err_col  out  1  sticky: a beat with req_col >= REGION_WORDS was seen

Behaviour:
- Reset (async, rst=1): bram_addr_a=BASE_ADDR, bram_wrdata_a=0, bram_we_a=0, frame_done=0, done_bank=0, wr_bank=0, err_col=0, done_mask=0, rr_ptr=0.
- Eligibility: channel i is eligible if req_valid[i]=1, done_mask[i]=0 and soft_clr=0.
- Grant: the first eligible channel searching upward from rr_ptr, wrapping modulo NUM_CH.
  - req_ready is one-hot or zero: only the granted channel sees ready=1.
  - ready does not depend on a prior valid/ready cycle.
- Accept: valid&ready on channel g.
  - On the next edge: rr_ptr <= (g+1) mod NUM_CH.
  - With no accept, rr_ptr holds.
- Write (latency 1):
  - Cycle after accept: bram_we_a=1.
  - bram_addr_a = BASE_ADDR + wr_bank*NUM_CH*REGION_WORDS + g*REGION_WORDS + col, truncated to ADDR_W.
  - bram_wrdata_a = channel g data.
  - With no accept, bram_we_a=0; addr/data hold their last values.
  - One write per cycle; back-to-back accepts give back-to-back writes.
- Out-of-range column: an accepted beat with col >= REGION_WORDS is still accepted and still counts toward last.
  - bram_we_a stays 0 for that beat.
  - err_col is set to 1 and stays set until rst.
- Completion:
  - An accepted beat with req_last sets done_mask[g] at the next edge.
  - A done channel gets no further grants, so it cannot overwrite the bank until the frame closes.
- Frame close:
  - Condition: done_mask | (accepted last bit) equals all ones.
  - On that edge: frame_done<=1 for exactly one cycle, done_bank<=wr_bank, wr_bank<=~wr_bank, done_mask<=0.
  - All channels are eligible again in the frame_done cycle, writing the new bank.
- soft_clr:
  - Has priority over any accept; no grant is issued in that cycle.
  - Next edge: wr_bank=0, done_mask=0, rr_ptr=0, bram_we_a=0, frame_done=0.
  - err_col and done_bank are unchanged.
- rst mid-write: all state returns to reset values immediately; a pending write is dropped.
- NUM_CH=1: arbitration degenerates, but bank and done logic are unchanged.

Decomposition:
- Package fmap_pkg holds:
  - localparam BANK_WORDS = NUM_CH*REGION_WORDS;
  - typedef of the channel-index type (logic [$clog2(NUM_CH)-1:0]);
  - function region_addr(bank, ch, col).
- Sub-module rr_arbiter (NUM_CH):
  - inputs: eligible vector, rr_ptr;
  - outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in the top level.

Test Plan:
- Single channel 0, 24 beats col 0..23 with last on 23, others idle → 24 writes at 0x000..0x017, no frame_done.
- All 4 channels valid continuously → grants cycle 0,1,2,3,0…; ch2 col 5 in bank 0 writes addr 0x035; one write per cycle, no gaps.
- All channels send last; ch3's last is accepted last → frame_done pulses the cycle after that accept with done_bank=0; wr_bank=1; next ch0 col 0 writes addr 0x060.
- ch1 finishes early and keeps valid high → req_ready[1]=0 until frame_done; no write to ch1 region of the bank it already finished.
- ch0 sends col=25 → accepted, bram_we_a stays 0 that cycle, err_col=1 and it survives soft_clr.
- soft_clr asserted with ch0 valid in bank 1 with done_mask=4'b0011 → no accept that cycle; then wr_bank=0, done_mask=0, rr_ptr=0.
- Assert rst while bram_we_a=1 → outputs go to reset values with no clock edge needed.
